fnd_scan_ctrl: RTL

Parametrised N-digit multiplexed seven-segment scan controller. It time-shares one segment bus across up to 8 common-node digits using a clock-enable prescaler in the system clock domain, with no generated clocks. It adds three things the fixed six-digit scanner lacks: a dead-time interval between digits, frame-coherent input latching, and per-digit blinking. It sits between the per-digit `fnd_dec` outputs and the board pins, and replaces `led_disp` in the top levels.

---
 rtl/fnd_pkg.sv | 13 +
 rtl/fnd_blink_gen.sv | 32 +++
 rtl/fnd_scan_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } fnd_scan_state_t;

    localparam logic [6:0] FND_SEG_BLANK  = 7'b0000000;
    localparam int         FND_MAX_DIGITS = 8;

endpackage

// File: rtl/fnd_blink_gen.sv
// Free-running blink phase generator: o_phase toggles every BLINK_DIV clocks,
// starting at 0 (visible) when reset is released.
module fnd_blink_gen #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_phase
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    // Half-period counter and phase toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign o_phase = phase_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller with dead time between
// digits, frame-coherent input shadows and optional per-digit blinking.
// Optional feature: define FND_SCAN_BLINK_EN to build the blink logic.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enb,
    input  logic [7*NUM_DIGITS-1:0] i_digit_seg,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    output logic [6:0]              o_seg,
    output logic                    o_seg_dp,
    output logic [NUM_DIGITS-1:0]   o_seg_enb,
    output logic                    o_frame_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    fnd_scan_state_t state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7*NUM_DIGITS-1:0] seg_sh_q, seg_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   enb_q, enb_d;
    logic                    tick_q, tick_d;
    logic                    latch;
    logic                    slot_end;
    logic                    drive;

`ifdef FND_SCAN_BLINK_EN
    logic [NUM_DIGITS-1:0]   mask_sh_q, mask_sh_d;
    logic                    blink_phase;

    fnd_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_phase (blink_phase)
    );
`else
    logic unused_blink_mask;
    localparam int unused_blink_div = BLINK_DIV;
    assign unused_blink_mask = ^i_blink_mask;
`endif

    // Next-state, shadow latching and registered-output selection
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        latch    = 1'b0;
        slot_end = 1'b0;
        drive    = 1'b0;

        if (!i_enb) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    latch   = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    state_d = DRIVE;
                    drive   = 1'b1;
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        if (DEAD_CYCLES == 0) begin
                            slot_end = 1'b1;
                        end else begin
                            state_d = DEAD;
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        drive = 1'b1;
                    end
                end
                DEAD: begin
                    if (cnt_q == SLOT_LAST) begin
                        slot_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A slot boundary starts the next digit; the wrap also starts a frame.
        if (slot_end) begin
            cnt_d   = '0;
            state_d = DRIVE;
            drive   = 1'b1;
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                latch  = 1'b1;
                tick_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        seg_sh_d = latch ? i_digit_seg : seg_sh_q;
        dp_sh_d  = latch ? i_dp        : dp_sh_q;
`ifdef FND_SCAN_BLINK_EN
        mask_sh_d = latch ? i_blink_mask : mask_sh_q;
`endif

        // Outputs reflect the upcoming state so they stay fully registered.
        enb_d = '1;
        seg_d = FND_SEG_BLANK;
        dp_d  = 1'b0;
        if (drive) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_d == IDX_W'(k)) begin
                    enb_d[k] = 1'b0;
                    seg_d    = seg_sh_d[7*k +: 7];
                    dp_d     = dp_sh_d[k];
`ifdef FND_SCAN_BLINK_EN
                    if (blink_phase && mask_sh_d[k]) begin
                        seg_d = FND_SEG_BLANK;
                        dp_d  = 1'b0;
                    end
`endif
                end
            end
        end
    end

    // Control state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            seg_q   <= FND_SEG_BLANK;
            dp_q    <= 1'b0;
            enb_q   <= '1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            enb_q   <= enb_d;
            tick_q  <= tick_d;
        end
    end

    // Frame shadows; only observed after a latch, so no reset is needed
    always_ff @(posedge clk) begin
        seg_sh_q <= seg_sh_d;
        dp_sh_q  <= dp_sh_d;
`ifdef FND_SCAN_BLINK_EN
        mask_sh_q <= mask_sh_d;
`endif
    end

    assign o_seg        = seg_q;
    assign o_seg_dp     = dp_q;
    assign o_seg_enb    = enb_q;
    assign o_frame_tick = tick_q;

endmodule
